// File: rtl/trace_pkg.sv
// ============================================================================
// trace_pkg : shared types and constants for the trace dump controller
// Revision  : 1.0
// ============================================================================
`default_nettype none

package trace_pkg;

  localparam int         TRACE_AW = 9;
  localparam int         DEPTH    = 2**TRACE_AW;
  localparam logic [7:0] HDR_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WAIT_RD = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    FIN     = 3'd5,
    HDR0    = 3'd6,
    HDR1    = 3'd7
  } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/trace_dump_ctrl_if.sv
// ============================================================================
// trace_dump_ctrl_if : command, trace RAM read and transmitter signals
// Revision           : 1.0
// ============================================================================
`default_nettype none

interface trace_dump_ctrl_if #(
  parameter int AW = 9,
  parameter int DW = 8
);

  logic          dump_req;
  logic          capture_done;
  logic [AW-1:0] trace_end;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] tx_data;
  logic          trmt;
  logic          tx_done;
  logic          dump_busy;
  logic          dump_nack;
  logic          dump_done;
  logic          clr_capture_done;

  modport master (
    input  dump_req, capture_done, trace_end, ram_rdata, tx_done,
    output ram_en, ram_addr, tx_data, trmt,
    output dump_busy, dump_nack, dump_done, clr_capture_done
  );

  modport slave (
    output dump_req, capture_done, trace_end, ram_rdata, tx_done,
    input  ram_en, ram_addr, tx_data, trmt,
    input  dump_busy, dump_nack, dump_done, clr_capture_done
  );

endinterface

`default_nettype wire

// File: rtl/trace_rd_ptr.sv
// ============================================================================
// trace_rd_ptr : wrapping trace RAM read pointer plus sent-byte counter
// Revision     : 1.0
// ============================================================================
`default_nettype none

module trace_rd_ptr #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic [AW-1:0] base_i,
  output logic [AW-1:0] ptr_o,
  output logic          last_o
);

  localparam logic [AW:0] CNT_LAST = (AW+1)'((2**AW) - 1);

  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  // Oldest sample sits just after the last written one; AW-bit add wraps.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      ptr_d = base_i + AW'(1);
      cnt_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/trace_dump_ctrl.sv
// ============================================================================
// trace_dump_ctrl : streams the capture trace RAM oldest-first to the UART.
// Define TRACE_DUMP_HDR_EN to prefix each dump with 0xA5 and trace_end[7:0].
// Revision        : 1.0
// ============================================================================
`default_nettype none

module trace_dump_ctrl
  import trace_pkg::*;
#(
  parameter int AW     = 9,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  trace_dump_ctrl_if.master        dump_if
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  dump_state_t   state_q, state_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          nack_q, nack_d;
  logic [1:0]    lat_q, lat_d;

  logic          w_ptr_load;
  logic          w_ptr_inc;
  logic [AW-1:0] w_ptr;
  logic          w_last;

`ifdef TRACE_DUMP_HDR_EN
  localparam logic [1:0] HB_NONE = 2'd0;
  localparam logic [1:0] HB_SYNC = 2'd1;
  localparam logic [1:0] HB_END  = 2'd2;

  logic [1:0]    hdr_q, hdr_d;
  logic [DW-1:0] w_end_byte;

  // Pointer was loaded with trace_end+1, so stepping back recovers trace_end.
  assign w_end_byte = DW'(w_ptr - AW'(1));
`endif

  trace_rd_ptr #(.AW(AW)) u_rd_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (w_ptr_load),
    .inc_i  (w_ptr_inc),
    .base_i (dump_if.trace_end),
    .ptr_o  (w_ptr),
    .last_o (w_last)
  );

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    nack_d     = 1'b0;
    lat_d      = lat_q;
    w_ptr_load = 1'b0;
    w_ptr_inc  = 1'b0;
`ifdef TRACE_DUMP_HDR_EN
    hdr_d      = hdr_q;
`endif
    case (state_q)
      IDLE: begin
        if (dump_if.dump_req) begin
          if (dump_if.capture_done) begin
            w_ptr_load = 1'b1;
`ifdef TRACE_DUMP_HDR_EN
            tx_data_d  = DW'(HDR_SYNC);
            state_d    = HDR0;
`else
            state_d    = RD;
`endif
          end else begin
            nack_d = 1'b1;
          end
        end
      end
      RD: begin
        lat_d   = '0;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (lat_q == LAT_LAST) begin
          tx_data_d = dump_if.ram_rdata;
          state_d   = SEND;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (dump_if.tx_done) begin
`ifdef TRACE_DUMP_HDR_EN
          if (hdr_q == HB_SYNC) begin
            tx_data_d = w_end_byte;
            state_d   = HDR1;
          end else if (hdr_q == HB_END) begin
            hdr_d   = HB_NONE;
            state_d = RD;
          end else begin
`endif
            w_ptr_inc = 1'b1;
            state_d   = w_last ? FIN : RD;
`ifdef TRACE_DUMP_HDR_EN
          end
`endif
        end
      end
      FIN: state_d = IDLE;
`ifdef TRACE_DUMP_HDR_EN
      HDR0: begin
        hdr_d   = HB_SYNC;
        state_d = WAIT_TX;
      end
      HDR1: begin
        hdr_d   = HB_END;
        state_d = WAIT_TX;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      nack_q    <= 1'b0;
      lat_q     <= '0;
`ifdef TRACE_DUMP_HDR_EN
      hdr_q     <= HB_NONE;
`endif
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      nack_q    <= nack_d;
      lat_q     <= lat_d;
`ifdef TRACE_DUMP_HDR_EN
      hdr_q     <= hdr_d;
`endif
    end
  end

  assign dump_if.ram_en           = (state_q == RD);
  assign dump_if.ram_addr         = w_ptr;
  assign dump_if.tx_data          = tx_data_q;
`ifdef TRACE_DUMP_HDR_EN
  assign dump_if.trmt             = (state_q == SEND) || (state_q == HDR0) || (state_q == HDR1);
`else
  assign dump_if.trmt             = (state_q == SEND);
`endif
  assign dump_if.dump_busy        = (state_q != IDLE);
  assign dump_if.dump_nack        = nack_q;
  assign dump_if.dump_done        = (state_q == FIN);
  assign dump_if.clr_capture_done = (state_q == FIN);

endmodule

`default_nettype wire

// File: tb/tb_trace_dump_ctrl.sv
// ============================================================================
// tb_trace_dump_ctrl : randomized scoreboard bench for trace_dump_ctrl
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_trace_dump_ctrl;
  import trace_pkg::*;

  localparam int AW     = 9;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;
  localparam int N      = 2**AW;
`ifdef TRACE_DUMP_HDR_EN
  localparam int HDRN   = 2;
`else
  localparam int HDRN   = 0;
`endif
  localparam int TMO    = 20000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trace_dump_ctrl_if #(.AW(AW), .DW(DW)) dif ();

  trace_dump_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dump_if (dif)
  );

  logic [DW-1:0] mem [N];
  logic [DW-1:0] exp_q [$];
  int  n_pass = 0, n_chk = 0;
  int  bytes_seen = 0, done_cnt = 0, clr_cnt = 0, nack_cnt = 0;
  int  busy_cycles = 0, en_cnt = 0, rd_idx = 0;
  int  exp_base = 0, first_addr = 0, last_addr = 0;
  bit  spur_mode = 1'b0;

  // Synchronous RAM with one cycle latency; garbage when not enabled.
  always @(posedge clk) begin
    if (dif.ram_en) dif.ram_rdata <= mem[dif.ram_addr];
    else            dif.ram_rdata <= DW'($urandom);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Transmitter model and byte scoreboard.
  initial begin
    int pend;
    logic [DW-1:0] sent;
    pend = 0;
    sent = '0;
    dif.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      dif.tx_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            chk("tx_data_hold", dif.tx_data, sent);
            dif.tx_done = 1'b1;
          end
        end
        if (dif.trmt) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL extra_byte: got %0h expected no byte", dif.tx_data);
          end else begin
            chk("tx_byte", dif.tx_data, exp_q.pop_front());
          end
          sent = dif.tx_data;
          bytes_seen++;
          if (spur_mode) dif.tx_done = 1'b1;
          pend = 1 + int'($urandom_range(0, 3));
        end
      end
    end
  end

  // Event monitor: pulses, busy, read addresses.
  initial begin
    bit busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_prev = 1'b0;
      end else begin
        if (dif.dump_done)        done_cnt++;
        if (dif.clr_capture_done) clr_cnt++;
        if (dif.dump_nack)        nack_cnt++;
        if (dif.dump_busy)        busy_cycles++;
        if (dif.dump_done || dif.clr_capture_done)
          chk("done_clr_pair", dif.clr_capture_done, dif.dump_done);
        if (dif.dump_busy && !busy_prev) rd_idx = 0;
        if (dif.ram_en) begin
          chk("ram_addr", dif.ram_addr, (exp_base + rd_idx) % N);
          if (rd_idx == 0) first_addr = dif.ram_addr;
          last_addr = dif.ram_addr;
          rd_idx++;
          en_cnt++;
        end
        busy_prev = dif.dump_busy;
      end
    end
  end

  task automatic start_dump(input int te);
    exp_base = (te + 1) % N;
`ifdef TRACE_DUMP_HDR_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(DW'(te % 256));
`endif
    for (int i = 0; i < N; i++) exp_q.push_back(mem[(te + 1 + i) % N]);
    dif.trace_end    = AW'(te);
    dif.capture_done = 1'b1;
    @(negedge clk);
    dif.dump_req = 1'b1;
    @(negedge clk);
    dif.dump_req = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int cyc;
    cyc = 0;
    while (done_cnt == d0 && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    if (done_cnt == d0) begin
      n_chk++;
      $display("FAIL dump_timeout: no dump_done after %0d cycles", cyc);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic full_dump_checks(input string tag, input int te, input int d0, input int c0,
                                  input int b0, input int e0);
    chk({tag, "_first_addr"}, first_addr, (te + 1) % N);
    chk({tag, "_last_addr"},  last_addr,  te);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_clr_pulses"},  clr_cnt - c0, 1);
    chk({tag, "_bytes"},       bytes_seen - b0, N + HDRN);
    chk({tag, "_ram_reads"},   en_cnt - e0, N);
    chk({tag, "_queue_left"},  exp_q.size(), 0);
    chk({tag, "_busy_after"},  dif.dump_busy, 0);
  endtask

  initial begin
    int d0, c0, b0, e0, n0, y0, te;
    rst_n            = 1'b0;
    dif.dump_req     = 1'b0;
    dif.capture_done = 1'b0;
    dif.trace_end    = '0;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);

    repeat (3) @(negedge clk);
    chk("reset_outputs", {dif.ram_en, dif.ram_addr, dif.tx_data, dif.trmt, dif.dump_busy,
                          dif.dump_nack, dif.dump_done, dif.clr_capture_done}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Request without a completed capture is refused.
    n0 = nack_cnt; y0 = busy_cycles; e0 = en_cnt; b0 = bytes_seen;
    dif.capture_done = 1'b0;
    dif.dump_req = 1'b1;
    @(negedge clk);
    dif.dump_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("nack_pulses", nack_cnt - n0, 1);
    chk("nack_busy",   busy_cycles - y0, 0);
    chk("nack_reads",  en_cnt - e0, 0);
    chk("nack_bytes",  bytes_seen - b0, 0);

    // Plain dump from trace_end = 0x0FF.
    d0 = done_cnt; c0 = clr_cnt; b0 = bytes_seen; e0 = en_cnt; n0 = nack_cnt;
    start_dump(9'h0FF);
    wait_done(d0);
    full_dump_checks("d1", 9'h0FF, d0, c0, b0, e0);

    // Wrap case with spurious tx_done, re-request and capture_done drop mid-dump.
    d0 = done_cnt; c0 = clr_cnt; b0 = bytes_seen; e0 = en_cnt;
    spur_mode = 1'b1;
    start_dump(9'h1FF);
    repeat (200) @(negedge clk);
    dif.capture_done = 1'b0;
    dif.dump_req = 1'b1;
    @(negedge clk);
    dif.dump_req = 1'b0;
    wait_done(d0);
    spur_mode = 1'b0;
    full_dump_checks("d2", 9'h1FF, d0, c0, b0, e0);
    chk("d2_no_nack", nack_cnt - n0, 0);

    // Reset after 100 bytes aborts, then a fresh dump restarts from trace_end+1.
    te = int'($urandom_range(0, N - 1));
    d0 = done_cnt; c0 = clr_cnt; b0 = bytes_seen;
    start_dump(te);
    begin
      int cyc;
      cyc = 0;
      while ((bytes_seen - b0) < 100 && cyc < TMO) begin
        @(negedge clk);
        cyc++;
      end
      chk("abort_reached_100", (bytes_seen - b0) >= 100, 1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {dif.ram_en, dif.ram_addr, dif.tx_data, dif.trmt, dif.dump_busy,
                          dif.dump_nack, dif.dump_done, dif.clr_capture_done}, 0);
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_clr",  clr_cnt - c0, 0);
    chk("abort_idle",    dif.dump_busy, 0);

    d0 = done_cnt; c0 = clr_cnt; b0 = bytes_seen; e0 = en_cnt;
    start_dump(te);
    wait_done(d0);
    full_dump_checks("d3", te, d0, c0, b0, e0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
